// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_hazard_ctrl_pkg: shared hazard FSM encodings and defaults
package pipeline_hazard_ctrl_pkg;
  typedef enum logic {HZ_RUN = 1'b0, HZ_MEM_WAIT = 1'b1} hz_state_t;
  localparam int DEF_MEM_TIMEOUT = 16;
endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// sat_counter: saturating event counter with synchronous clear
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc && !(&cnt)) cnt <= cnt + CNT_W'(1);
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use, redirect and memory-wait scheduler with perf counters
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W  = 5,
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic                  ex_memread,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  id_redirect,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  input  logic                  clr_cnt,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  ifid_flush,
  output logic                  ctrl_stall,
  output logic                  pipe_freeze,
  output logic                  mem_timeout,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  hz_state_t state, state_nx;
  logic [WW-1:0] wcnt, wcnt_nx;
  logic lu, miss, to_evt, wait_left;
  always_comb begin
    lu = ex_memread && ex_rd != '0 &&
         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    miss = mem_req && !mem_ready;
    wait_left = wcnt < WW'(MEM_TIMEOUT);
    pipe_freeze = state == HZ_RUN ? miss : (!mem_ready && wait_left);
    pc_write = !pipe_freeze && !lu;
    ifid_write = !pipe_freeze && !lu;
    ctrl_stall = !pipe_freeze && lu;
    ifid_flush = !pipe_freeze && !lu && id_redirect;
  end
  // the access that exhausts its budget is abandoned and the instruction retires
  always_comb begin
    state_nx = state;
    wcnt_nx = wcnt;
    to_evt = 1'b0;
    if (state == HZ_RUN) begin
      state_nx = miss ? HZ_MEM_WAIT : HZ_RUN;
      wcnt_nx = miss ? WW'(1) : wcnt;
    end else if (mem_ready || !wait_left) begin
      state_nx = HZ_RUN;
      wcnt_nx = '0;
      to_evt = !mem_ready;
    end else begin
      wcnt_nx = wcnt + WW'(1);
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= HZ_RUN;
      wcnt <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state <= state_nx;
      wcnt <= wcnt_nx;
      mem_timeout <= clr_cnt ? 1'b0 : (mem_timeout || to_evt);
    end
  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst_n(rst_n), .inc(ctrl_stall || pipe_freeze), .clr(clr_cnt), .cnt(stall_cnt)
  );
  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk(clk), .rst_n(rst_n), .inc(ifid_flush), .clr(clr_cnt), .cnt(flush_cnt)
  );
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed checks of hazard scheduling, timeout and counters
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic id_use_rs1 = 0, id_use_rs2 = 0, ex_memread = 0, id_redirect = 0;
  logic mem_req = 0, mem_ready = 0, clr_cnt = 0;
  logic pc_write, ifid_write, ifid_flush, ctrl_stall, pipe_freeze, mem_timeout;
  logic [31:0] stall_cnt, flush_cnt;
  logic s_pc_write, s_ifid_write, s_ifid_flush, s_ctrl_stall, s_pipe_freeze, s_mem_timeout;
  logic [3:0] s_stall_cnt, s_flush_cnt;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_ADDR_W(5), .MEM_TIMEOUT(16), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_memread(ex_memread),
    .ex_rd(ex_rd), .id_redirect(id_redirect), .mem_req(mem_req), .mem_ready(mem_ready),
    .clr_cnt(clr_cnt), .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .ctrl_stall(ctrl_stall), .pipe_freeze(pipe_freeze),
    .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipeline_hazard_ctrl #(.REG_ADDR_W(5), .MEM_TIMEOUT(16), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_memread(ex_memread),
    .ex_rd(ex_rd), .id_redirect(id_redirect), .mem_req(mem_req), .mem_ready(mem_ready),
    .clr_cnt(clr_cnt), .pc_write(s_pc_write), .ifid_write(s_ifid_write),
    .ifid_flush(s_ifid_flush), .ctrl_stall(s_ctrl_stall), .pipe_freeze(s_pipe_freeze),
    .mem_timeout(s_mem_timeout), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lu(input logic on);
    ex_memread = on;
    ex_rd = on ? 5'd5 : 5'd0;
    id_rs2 = on ? 5'd5 : 5'd0;
    id_use_rs2 = on;
  endtask

  initial begin
    #3;
    chk("rst_pc_write", pc_write, 1);
    chk("rst_ifid_write", ifid_write, 1);
    chk("rst_ctrl_stall", ctrl_stall, 0);
    chk("rst_ifid_flush", ifid_flush, 0);
    chk("rst_freeze", pipe_freeze, 0);
    chk("rst_timeout", mem_timeout, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_flush_cnt", flush_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    set_lu(1);
    #1;
    chk("lu_pc_write", pc_write, 0);
    chk("lu_ifid_write", ifid_write, 0);
    chk("lu_stall", ctrl_stall, 1);
    chk("lu_cnt_before", stall_cnt, 0);
    tick();
    set_lu(0);
    #1;
    chk("lu_bubble_stall", ctrl_stall, 0);
    chk("lu_bubble_pc", pc_write, 1);
    chk("lu_cnt_after", stall_cnt, 1);
    ex_memread = 1; ex_rd = 0; id_rs2 = 0; id_use_rs2 = 1;
    #1;
    chk("x0_stall", ctrl_stall, 0);
    ex_rd = 7; id_rs1 = 7; id_use_rs1 = 0; id_rs2 = 0; id_use_rs2 = 0;
    #1;
    chk("unused_rs1_stall", ctrl_stall, 0);
    ex_memread = 0; ex_rd = 0; id_rs1 = 0;
    tick();
    id_redirect = 1;
    #1;
    chk("redir_flush", ifid_flush, 1);
    chk("redir_pc", pc_write, 1);
    chk("redir_cnt_before", flush_cnt, 0);
    tick();
    id_redirect = 0;
    #1;
    chk("redir_flush_off", ifid_flush, 0);
    chk("redir_cnt_after", flush_cnt, 1);
    id_redirect = 1;
    set_lu(1);
    #1;
    chk("redir_lu_flush", ifid_flush, 0);
    chk("redir_lu_stall", ctrl_stall, 1);
    tick();
    set_lu(0);
    #1;
    chk("redir_retry_flush", ifid_flush, 1);
    tick();
    id_redirect = 0;
    #1;
    chk("redir_stall_cnt", stall_cnt, 2);
    chk("redir_flush_cnt", flush_cnt, 2);
    mem_req = 1; mem_ready = 0;
    set_lu(1);
    #1;
    chk("miss_lu_freeze", pipe_freeze, 1);
    chk("miss_lu_stall", ctrl_stall, 0);
    chk("miss_pc_write", pc_write, 0);
    tick();
    set_lu(0);
    #1;
    chk("wait2_freeze", pipe_freeze, 1);
    tick();
    chk("wait3_freeze", pipe_freeze, 1);
    tick();
    mem_ready = 1;
    #1;
    chk("ready_freeze", pipe_freeze, 0);
    chk("ready_pc_write", pc_write, 1);
    chk("wait_stall_cnt", stall_cnt, 5);
    tick();
    mem_req = 0; mem_ready = 0;
    #1;
    chk("back_in_run", pipe_freeze, 0);
    chk("back_stall_cnt", stall_cnt, 5);
    tick();
    mem_req = 1;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk($sformatf("to_freeze_%0d", i), pipe_freeze, 1);
      tick();
    end
    #1;
    chk("to_release", pipe_freeze, 0);
    chk("to_release_pc", pc_write, 1);
    chk("to_flag_pending", mem_timeout, 0);
    tick();
    mem_req = 0;
    #1;
    chk("to_flag_set", mem_timeout, 1);
    chk("to_stall_cnt", stall_cnt, 21);
    chk("sat_stall_cnt", s_stall_cnt, 15);
    chk("sat_flush_cnt", s_flush_cnt, 2);
    tick();
    chk("to_flag_sticky", mem_timeout, 1);
    clr_cnt = 1;
    id_redirect = 1;
    tick();
    clr_cnt = 0;
    id_redirect = 0;
    #1;
    chk("clr_timeout", mem_timeout, 0);
    chk("clr_stall_cnt", stall_cnt, 0);
    chk("clr_flush_cnt", flush_cnt, 0);
    chk("clr_sat_cnt", s_stall_cnt, 0);
    mem_req = 1;
    #1;
    chk("rw_freeze_run", pipe_freeze, 1);
    tick();
    mem_req = 0;
    #1;
    chk("rw_freeze_wait", pipe_freeze, 1);
    #1;
    rst_n = 0;
    #1;
    chk("rw_async_release", pipe_freeze, 0);
    chk("rw_async_cnt", stall_cnt, 0);
    @(negedge clk);
    rst_n = 1;
    tick();
    #1;
    chk("post_rst_pc", pc_write, 1);
    chk("post_rst_freeze", pipe_freeze, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
